gh_uart_tx_fifo: RTL

GH_UART_TX_FIFO -- requirements
Module: gh_uart_tx_fifo

---
 rtl/gh_uart_pkg.sv | 11 +
 rtl/gh_uart_tx_fifo_if.sv | 30 +++
 rtl/gh_ram_dp_async_rd.sv | 23 ++
 rtl/gh_uart_tx_fifo.sv | 98 +++++++++
 4 files changed

// File: rtl/gh_uart_pkg.sv
// Constants shared by the UART TX and RX FIFOs.
package gh_uart_pkg;

    localparam int UART_FIFO_DEPTH = 16;
    localparam int UART_DATA_W     = 8;

    function automatic int fifo_cnt_w(input int depth);
        return $clog2(depth) + 1;
    endfunction

endpackage

// File: rtl/gh_uart_tx_fifo_if.sv
// Bus-side and transmitter-side signals of the UART TX FIFO.
// master = bus/transmitter side, slave = the FIFO itself.
interface gh_uart_tx_fifo_if
    import gh_uart_pkg::*;
#(
    parameter int DEPTH = UART_FIFO_DEPTH,
    parameter int WIDTH = UART_DATA_W
);
    logic                        srst;
    logic                        wr;
    logic [WIDTH-1:0]            d;
    logic                        rd;
    logic                        ovf_clr;
    logic [WIDTH-1:0]            q;
    logic                        d_ryn;
    logic                        full;
    logic                        empty;
    logic [fifo_cnt_w(DEPTH)-1:0] count;
    logic                        ovf;

    modport master (
        output srst, wr, d, rd, ovf_clr,
        input  q, d_ryn, full, empty, count, ovf
    );

    modport slave (
        input  srst, wr, d, rd, ovf_clr,
        output q, d_ryn, full, empty, count, ovf
    );
endinterface

// File: rtl/gh_ram_dp_async_rd.sv
// Simple dual-port RAM: synchronous write port, asynchronous read port.
module gh_ram_dp_async_rd #(
    parameter int AW = 4,
    parameter int W  = 8
) (
    input  logic          clk,
    input  logic          i_we,
    input  logic [AW-1:0] i_waddr,
    input  logic [W-1:0]  i_wdata,
    input  logic [AW-1:0] i_raddr,
    output logic [W-1:0]  o_rdata
);
    logic [W-1:0] r_mem [0:(1<<AW)-1];

    // NOTE: storage has no reset so it maps onto RAM/LUTRAM; readers qualify data with flags.
    always_ff @(posedge clk) begin
        if (i_we) begin
            r_mem[i_waddr] <= i_wdata;
        end
    end

    assign o_rdata = r_mem[i_raddr];
endmodule

// File: rtl/gh_uart_tx_fifo.sv
// Show-ahead UART transmit FIFO with sticky overflow flag.
// Define GH_UART_TX_FIFO_OVF_EN to enable the overflow flag; otherwise ovf is tied low.
module gh_uart_tx_fifo
    import gh_uart_pkg::*;
#(
    parameter int DEPTH = UART_FIFO_DEPTH,
    parameter int WIDTH = UART_DATA_W
) (
    input  logic              clk,
    input  logic              rst,
    gh_uart_tx_fifo_if.slave  bus
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = fifo_cnt_w(DEPTH);

    logic [AW-1:0]    r_rd_ptr;
    logic [AW-1:0]    r_wr_ptr;
    logic [CW-1:0]    r_count;
    logic             w_empty;
    logic             w_full;
    logic             w_rd_acc;
    logic             w_wr_acc;
    logic             w_we;
    logic [WIDTH-1:0] w_q;

    // NOTE: flags decode registered count only, so they change the cycle after the strobe.
    assign w_empty  = (r_count == '0);
    assign w_full   = (r_count == CW'(DEPTH));
    assign w_rd_acc = bus.rd & ~w_empty;
    assign w_wr_acc = bus.wr & (~w_full | w_rd_acc);
    assign w_we     = w_wr_acc & ~bus.srst;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_rd_ptr <= '0;
            r_wr_ptr <= '0;
            r_count  <= '0;
        end else if (bus.srst) begin
            r_rd_ptr <= '0;
            r_wr_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_wr_acc) begin
                r_wr_ptr <= r_wr_ptr + AW'(1);
            end
            if (w_rd_acc) begin
                r_rd_ptr <= r_rd_ptr + AW'(1);
            end
            case ({w_wr_acc, w_rd_acc})
                2'b10:   r_count <= r_count + CW'(1);
                2'b01:   r_count <= r_count - CW'(1);
                default: r_count <= r_count;
            endcase
        end
    end

`ifdef GH_UART_TX_FIFO_OVF_EN
    logic r_ovf;

    // A fresh overflow wins over a simultaneous clear.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_ovf <= 1'b0;
        end else if (bus.srst) begin
            r_ovf <= 1'b0;
        end else if (bus.wr & ~w_wr_acc) begin
            r_ovf <= 1'b1;
        end else if (bus.ovf_clr) begin
            r_ovf <= 1'b0;
        end
    end

    assign bus.ovf = r_ovf;
`else
    logic w_unused_ovf_clr;

    assign w_unused_ovf_clr = bus.ovf_clr;
    assign bus.ovf          = 1'b0;
`endif

    gh_ram_dp_async_rd #(
        .AW (AW),
        .W  (WIDTH)
    ) u_ram (
        .clk     (clk),
        .i_we    (w_we),
        .i_waddr (r_wr_ptr),
        .i_wdata (bus.d),
        .i_raddr (r_rd_ptr),
        .o_rdata (w_q)
    );

    assign bus.q     = w_q;
    assign bus.count = r_count;
    assign bus.empty = w_empty;
    assign bus.full  = w_full;
    assign bus.d_ryn = w_empty;
endmodule
